pkt_wr_sched: RTL and testbench
===============================

// Module: pkt_wr_sched
// PURPOSE
// Sequences the packet write controller. Accepts captured-packet descriptors (begin/end byte
// pointers into the packet FIFO stream) over a valid/ready handshake, allocates space in a
// host-memory ring buffer, issues one wr_ctrl request per packet and commits the ring write
// offset once the controller reports done. Sits between the packet capture front end and the
// Avalon-MM write controller; software drains the ring and returns its read offset.
// PARAMETERS
// MAX_PKT_BYTES   16'd1518   largest accepted packet; longer descriptors are dropped
// TIMEOUT_CYCLES  24'd65535  cycles to wait for wr_ctrl_rdy before flagging an error
// PORTS
// clk            in   1   system clock
// reset          in   1   asynchronous active-low reset
// enable         in   1   1 = accept new descriptors; 0 = finish in-flight packet, then idle
// desc_valid     in   1   descriptor present
// desc_ready     out  1   descriptor accepted when desc_valid && desc_ready
// desc_begin     in   32  packet start pointer
// desc_end       in   32  packet end pointer (exclusive)
// ring_base      in   32  host byte address of ring start (word aligned)
// ring_size      in   32  ring length in bytes (multiple of 4, >= 2*MAX_PKT_BYTES)
// sw_rd_off      in   32  software read offset into ring (bytes, word aligned)
// wr_ctrl        out  1   one-cycle start pulse to write controller
// wr_ctrl_rdy    in   1   one-cycle done pulse from write controller
// pkt_begin      out  32  held stable from wr_ctrl pulse until wr_ctrl_rdy
// pkt_end        out  32  as above
// write_address  out  32  ring_base + allocated offset; held as above
// control        out  32  {16'h0, len[15:0]}; held as above
// wr_off         out  32  committed ring write offset (bytes)
// pkt_count      out  32  packets committed (wraps at 2^32)
// drop_count     out  16  descriptors dropped (saturates at 16'hFFFF)
// err_timeout    out  1   sticky; set on timeout, cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (desc_ready, wr_ctrl, pkt_*, write_address, control,
//   wr_off, pkt_count, drop_count, err_timeout).
// - len = (desc_end - desc_begin) in 32-bit modulo arithmetic, rounded up to a multiple of 4
//   (upper 16 bits checked before truncation to 16 bits).
// - States: IDLE -> ALLOC -> ISSUE -> WAIT -> COMMIT -> IDLE.
//   IDLE: desc_ready = enable. On handshake, latch begin/end/len and go to ALLOC.
//         len == 0 or len > MAX_PKT_BYTES: drop_count++, stay in IDLE, no wr_ctrl issued.
//   ALLOC: occ = (wr_off - sw_rd_off) mod ring_size; free = ring_size - occ - 4 (one-word gap).
//         If wr_off + len <= ring_size: fits when len <= free; alloc = wr_off.
//         Otherwise wrap: the tail is skipped; fits when (ring_size - wr_off) + len <= free;
//         alloc = 0.
//         No fit: stall in ALLOC and re-evaluate every cycle (sw_rd_off may move). Never drop.
//   ISSUE: drive pkt_*, write_address, control; pulse wr_ctrl high for exactly 1 cycle;
//         load the timeout counter.
//   WAIT: hold outputs. wr_ctrl_rdy -> COMMIT. Counter reaching TIMEOUT_CYCLES sets
//         err_timeout and returns to IDLE without commit; wr_off is unchanged.
//         A wr_ctrl_rdy pulse seen outside WAIT is ignored.
//   COMMIT: wr_off <= alloc + len, and 0 if the sum == ring_size. pkt_count++. Go to IDLE.
// - Latency: descriptor handshake to wr_ctrl pulse = 3 cycles when space is free (ALLOC, ISSUE).
//   wr_ctrl_rdy to the next desc_ready = 2 cycles.
// - enable falling mid-packet does not abort; the scheduler completes the packet, then
//   desc_ready stays 0.
// - ring_base, ring_size and sw_rd_off are sampled live. ring_base and ring_size may only
//   change while in IDLE with enable = 0.
// STRUCTURE
// - Shared package pkt_wr_pkg: typedef enum logic [2:0] sched_state_t
//   {IDLE, ALLOC, ISSUE, WAIT, COMMIT}; localparam WORD_BYTES = 4.
// - One sub-module, ring_space_calc: combinational occ/free/fit/alloc computation from
//   wr_off, sw_rd_off, ring_size and len. Keeps the FSM file to sequencing only.
// TESTING
// 1 Single packet: base=0x1000, size=0x1000, begin=0, end=64 -> wr_ctrl pulse 3 cycles after
//   the handshake, write_address=0x1000, control=64; after rdy, wr_off=64, pkt_count=1.
// 2 Round-up: begin=0, end=61 -> control=64, wr_off advances by 64.
// 3 Wrap: wr_off=0xFC0, sw_rd_off=0x800, len=0x80 -> write_address=ring_base, wr_off=0x80.
// 4 Full stall: wr_off=0x7F0, sw_rd_off=0x800, len=64 -> stays in ALLOC, desc_ready=0,
//   no wr_ctrl; set sw_rd_off=0x900 -> issues within 2 cycles.
// 5 Drops: len=0, then len=2000 -> drop_count=2, no wr_ctrl, desc_ready back to 1
//   the next cycle.
// 6 Timeout/reset: withhold wr_ctrl_rdy for TIMEOUT_CYCLES -> err_timeout=1, wr_off unchanged;
//   assert reset in WAIT -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/pkt_wr_pkg.sv
// Shared types for the packet write scheduler.
//   sched_state_t : sequencing states of pkt_wr_sched
//   desc_t        : latched descriptor (begin/end pointers, rounded length)
//   round_len()   : end-begin, rounded up to whole words, kept 33 bits wide so
//                   huge or negative spans cannot wrap to a small length
package pkt_wr_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {IDLE, ALLOC, ISSUE, WAIT, COMMIT} sched_state_t;

  typedef struct packed {
    logic [31:0] pbegin;
    logic [31:0] pend;
    logic [15:0] len;
  } desc_t;

  function automatic logic [32:0] round_len(input logic [31:0] b, input logic [31:0] e);
    logic [32:0] sum;
    sum = {1'b0, e - b} + 33'(WORD_BYTES - 1);
    return sum & ~33'(WORD_BYTES - 1);
  endfunction
endpackage

// File: rtl/pkt_wr_sched_if.sv
// Descriptor handshake plus write-controller request bus.
//   desc_valid/desc_ready/desc_begin/desc_end : capture front end -> scheduler
//   wr_ctrl/pkt_begin/pkt_end/write_address/control : scheduler -> write controller
//   wr_ctrl_rdy : write controller done pulse
// master = environment side, slave = scheduler side.
interface pkt_wr_sched_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_begin;
  logic [31:0] desc_end;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic [31:0] write_address;
  logic [31:0] control;

  modport master (
    output desc_valid, desc_begin, desc_end, wr_ctrl_rdy,
    input  desc_ready, wr_ctrl, pkt_begin, pkt_end, write_address, control
  );
  modport slave (
    input  desc_valid, desc_begin, desc_end, wr_ctrl_rdy,
    output desc_ready, wr_ctrl, pkt_begin, pkt_end, write_address, control
  );
endinterface

// File: rtl/pkt_wr_sched_ring.sv
// ring_space_calc: combinational ring-buffer space check.
//   wr_off, sw_rd_off, ring_size : current ring state (bytes)
//   len                          : rounded packet length
//   fit                          : packet can be placed now
//   alloc                        : ring offset for the packet (wr_off, or 0 on wrap)
// One word is always kept free so full and empty are distinguishable.
module ring_space_calc
  import pkt_wr_pkg::*;
(
  input  logic [31:0] wr_off,
  input  logic [31:0] sw_rd_off,
  input  logic [31:0] ring_size,
  input  logic [15:0] len,
  output logic        fit,
  output logic [31:0] alloc
);
  logic [32:0] occ, free, need, end_off;

  always_comb begin
    if (wr_off >= sw_rd_off) occ = {1'b0, wr_off - sw_rd_off};
    else                     occ = {1'b0, wr_off} + {1'b0, ring_size} - {1'b0, sw_rd_off};
    free    = {1'b0, ring_size} - occ - 33'(WORD_BYTES);
    end_off = {1'b0, wr_off} + {17'b0, len};
    if (end_off <= {1'b0, ring_size}) begin
      need  = {17'b0, len};
      alloc = wr_off;
    end else begin
      // tail past wr_off is abandoned, so it counts against free space
      need  = {1'b0, ring_size} - {1'b0, wr_off} + {17'b0, len};
      alloc = '0;
    end
    // free[32] guards against a bogus sw_rd_off making free negative
    fit = !free[32] && (need <= free);
  end
endmodule

// File: rtl/pkt_wr_sched.sv
// pkt_wr_sched: accepts packet descriptors, allocates ring space, issues one
// write-controller request per packet and commits the ring write offset.
//   clk, reset (async, active low), enable
//   bus        : descriptor handshake + write controller request (slave side)
//   ring_base, ring_size, sw_rd_off : ring configuration / software read offset
//   wr_off, pkt_count, drop_count, err_timeout : status
module pkt_wr_sched
  import pkt_wr_pkg::*;
#(
  parameter logic [15:0] MAX_PKT_BYTES  = 16'd1518,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pkt_wr_sched_if.slave        bus,
  input  logic [31:0]          ring_base,
  input  logic [31:0]          ring_size,
  input  logic [31:0]          sw_rd_off,
  output logic [31:0]          wr_off,
  output logic [31:0]          pkt_count,
  output logic [15:0]          drop_count,
  output logic                 err_timeout
);
  sched_state_t state, state_nx;
  desc_t        desc_q;
  logic [31:0]  alloc_q;
  logic [23:0]  tmo_cnt;
  logic         desc_ready_q, wr_ctrl_q;
  logic [31:0]  pkt_begin_q, pkt_end_q, write_address_q, control_q;

  logic [32:0]  len_full;
  logic         hs, drop, fit, tmo_hit;
  logic [31:0]  alloc, commit_sum, commit_off;

  assign bus.desc_ready    = desc_ready_q;
  assign bus.wr_ctrl       = wr_ctrl_q;
  assign bus.pkt_begin     = pkt_begin_q;
  assign bus.pkt_end       = pkt_end_q;
  assign bus.write_address = write_address_q;
  assign bus.control       = control_q;

  assign len_full   = round_len(bus.desc_begin, bus.desc_end);
  assign drop       = (len_full == '0) || (len_full > {17'b0, MAX_PKT_BYTES});
  assign hs         = (state == IDLE) && bus.desc_valid && desc_ready_q;
  assign tmo_hit    = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign commit_sum = alloc_q + {16'h0, desc_q.len};
  assign commit_off = (commit_sum == ring_size) ? '0 : commit_sum;

  ring_space_calc u_space (
    .wr_off    (wr_off),
    .sw_rd_off (sw_rd_off),
    .ring_size (ring_size),
    .len       (desc_q.len),
    .fit       (fit),
    .alloc     (alloc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs && !drop) state_nx = ALLOC;
      ALLOC:   if (fit) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.wr_ctrl_rdy) state_nx = COMMIT;
               else if (tmo_hit)    state_nx = IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      desc_q          <= '0;
      alloc_q         <= '0;
      tmo_cnt         <= '0;
      desc_ready_q    <= 1'b0;
      wr_ctrl_q       <= 1'b0;
      pkt_begin_q     <= '0;
      pkt_end_q       <= '0;
      write_address_q <= '0;
      control_q       <= '0;
      wr_off          <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
      err_timeout     <= 1'b0;
    end else begin
      state        <= state_nx;
      // ready is registered so it is 0 out of reset and drops on the accept edge
      desc_ready_q <= (state_nx == IDLE) && enable;
      // single-cycle pulse, visible during the first WAIT cycle
      wr_ctrl_q    <= (state == ISSUE);

      if (hs) begin
        if (drop) begin
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else begin
          desc_q <= '{pbegin: bus.desc_begin, pend: bus.desc_end, len: len_full[15:0]};
        end
      end

      // request fields are loaded a cycle ahead of the pulse and held until next packet
      if (state == ALLOC && fit) begin
        alloc_q         <= alloc;
        pkt_begin_q     <= desc_q.pbegin;
        pkt_end_q       <= desc_q.pend;
        write_address_q <= ring_base + alloc;
        control_q       <= {16'h0, desc_q.len};
      end

      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 24'd1;

      if (state == WAIT && !bus.wr_ctrl_rdy && tmo_hit) err_timeout <= 1'b1;

      if (state == COMMIT) begin
        wr_off    <= commit_off;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pkt_wr_sched.sv
// Directed bench for pkt_wr_sched with a scoreboard of expected requests.
module tb_pkt_wr_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] ring_base = 32'h1000;
  logic [31:0] ring_size = 32'h1000;
  logic [31:0] sw_rd_off = 32'h0;
  logic [31:0] wr_off, pkt_count;
  logic [15:0] drop_count;
  logic        err_timeout;

  pkt_wr_sched_if bus();

  pkt_wr_sched #(.MAX_PKT_BYTES(16'd1518), .TIMEOUT_CYCLES(24'd200)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .ring_base(ring_base), .ring_size(ring_size), .sw_rd_off(sw_rd_off),
    .wr_off(wr_off), .pkt_count(pkt_count), .drop_count(drop_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, ctl, pb, pe;
    int          hs;   // rising edge of the handshake, -1 = latency not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_vld = 0;
  bit   prev_wr = 0;
  bit   hold_rdy = 0;
  int   rdy_dly = 3;
  int   errors = 0, checks = 0, cyc = 0, n_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: pop one expectation per wr_ctrl pulse
  always @(negedge clk) begin
    if (reset && bus.wr_ctrl) begin
      n_pulse++;
      chk("wr_ctrl_width", 32'(prev_wr), 0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wr_ctrl: got addr 0x%08h want no request", bus.write_address);
      end else begin
        cur = exp_q.pop_front();
        cur_vld = 1;
        chk("write_address", bus.write_address, cur.addr);
        chk("control", bus.control, cur.ctl);
        chk("pkt_begin", bus.pkt_begin, cur.pb);
        chk("pkt_end", bus.pkt_end, cur.pe);
        if (cur.hs >= 0) chk("issue_latency", 32'(cyc + 1 - cur.hs), 3);
      end
    end
    if (reset && bus.wr_ctrl_rdy && cur_vld) begin
      chk("held_address", bus.write_address, cur.addr);
      chk("held_control", bus.control, cur.ctl);
      cur_vld = 0;
    end
    prev_wr = bus.wr_ctrl;
  end

  // write controller model: done pulse rdy_dly cycles after the start pulse
  initial begin
    bus.wr_ctrl_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.wr_ctrl && !hold_rdy) begin
        repeat (rdy_dly - 1) @(negedge clk);
        #1 bus.wr_ctrl_rdy = 1'b1;
        @(negedge clk);
        #1 bus.wr_ctrl_rdy = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] e, input logic [31:0] addr,
                      input logic [31:0] ctl, input bit chk_lat, input bit issue);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    bus.desc_begin = b; bus.desc_end = e; bus.desc_valid = 1'b1;
    while (!bus.desc_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.desc_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got desc_ready=0 want 1 (begin 0x%08h)", b);
      bus.desc_valid = 1'b0;
      return;
    end
    if (issue) begin
      x.addr = addr; x.ctl = ctl; x.pb = b; x.pe = e;
      x.hs = chk_lat ? cyc + 1 : -1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1 bus.desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.desc_ready && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!bus.desc_ready) begin
      errors++;
      $display("FAIL %s_idle: got desc_ready=0 want 1", tag);
    end
  endtask

  task automatic pkt(input logic [31:0] b, input logic [31:0] e, input logic [31:0] addr,
                     input logic [31:0] ctl, input logic [31:0] off, input logic [31:0] cnt);
    send(b, e, addr, ctl, 1, 1);
    wait_idle("pkt");
    chk("wr_off", wr_off, off);
    chk("pkt_count", pkt_count, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    bus.desc_valid = 1'b0; bus.desc_begin = '0; bus.desc_end = '0;

    // reset values with enable already high
    repeat (3) @(negedge clk);
    chk("rst_desc_ready", 32'(bus.desc_ready), 0);
    chk("rst_wr_ctrl", 32'(bus.wr_ctrl), 0);
    chk("rst_write_address", bus.write_address, 0);
    chk("rst_control", bus.control, 0);
    chk("rst_wr_off", wr_off, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_err", 32'(err_timeout), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.desc_ready), 1);

    // single packet, then a length that rounds up
    pkt(32'h0,   32'h40,  32'h1000, 32'h40, 32'h40, 1);
    pkt(32'h100, 32'h13D, 32'h1040, 32'h40, 32'h80, 2);

    // drops: zero, too long, negative span, 1517 rounds to 1520
    p0 = n_pulse;
    send(32'h20, 32'h20, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop0_ready", 32'(bus.desc_ready), 1);
    chk("drop0_count", 32'(drop_count), 1);
    send(32'h0, 32'd2000, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop1_ready", 32'(bus.desc_ready), 1);
    chk("drop1_count", 32'(drop_count), 2);
    send(32'h100, 32'h0, 0, 0, 0, 0);
    send(32'h0, 32'd1517, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop_count_total", 32'(drop_count), 4);
    chk("drop_no_issue", 32'(n_pulse), 32'(p0));
    chk("drop_wr_off", wr_off, 32'h80);

    // advance wr_off to 0x7F0 (1516 = largest accepted length)
    pkt(32'h0, 32'h5EC, 32'h1080, 32'h5EC, 32'h66C, 3);
    pkt(32'h0, 32'h184, 32'h166C, 32'h184, 32'h7F0, 4);

    // full ring: stall in ALLOC until software frees space
    sw_rd_off = 32'h800;
    p0 = n_pulse;
    send(32'h40, 32'h80, 32'h17F0, 32'h40, 0, 1);
    repeat (8) @(negedge clk);
    chk("stall_ready", 32'(bus.desc_ready), 0);
    chk("stall_no_issue", 32'(n_pulse), 32'(p0));
    sw_rd_off = 32'h900;
    repeat (2) @(negedge clk);
    #1 chk("stall_release", 32'(n_pulse), 32'(p0 + 1));
    wait_idle("stall");
    chk("stall_wr_off", wr_off, 32'h830);
    chk("stall_pkt_count", pkt_count, 5);

    // advance to 0xFC0 with the ring drained
    sw_rd_off = 32'h830;
    pkt(32'h0, 32'h5EC, 32'h1830, 32'h5EC, 32'hE1C, 6);
    pkt(32'h0, 32'h1A4, 32'h1E1C, 32'h1A4, 32'hFC0, 7);

    // wrap: tail skipped, packet placed at ring start
    sw_rd_off = 32'h800;
    pkt(32'h200, 32'h280, 32'h1000, 32'h80, 32'h80, 8);

    // stray done pulse while idle is ignored
    @(negedge clk);
    #1 bus.wr_ctrl_rdy = 1'b1;
    @(negedge clk);
    #1 bus.wr_ctrl_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_wr_off", wr_off, 32'h80);
    chk("stray_pkt_count", pkt_count, 8);

    // enable falls mid-packet: packet completes, no further accepts
    rdy_dly = 10;
    p0 = n_pulse;
    send(32'h300, 32'h340, 32'h1080, 32'h40, 1, 1);
    enable = 1'b0;
    bus.desc_begin = 32'h0; bus.desc_end = 32'h40; bus.desc_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("disable_pkt_count", pkt_count, 9);
    chk("disable_wr_off", wr_off, 32'hC0);
    chk("disable_ready", 32'(bus.desc_ready), 0);
    chk("disable_pulses", 32'(n_pulse), 32'(p0 + 1));
    bus.desc_valid = 1'b0;
    enable = 1'b1;
    rdy_dly = 3;

    // timeout: no done pulse
    hold_rdy = 1;
    send(32'h400, 32'h440, 32'h10C0, 32'h40, 1, 1);
    repeat (100) @(negedge clk);
    chk("err_early", 32'(err_timeout), 0);
    n = 0;
    while (!err_timeout && n < 300) begin @(negedge clk); n++; end
    chk("err_timeout", 32'(err_timeout), 1);
    wait_idle("timeout");
    chk("timeout_wr_off", wr_off, 32'hC0);
    chk("timeout_pkt_count", pkt_count, 9);

    // reset while waiting on the controller clears everything at once
    p0 = n_pulse;
    send(32'h500, 32'h540, 32'h10C0, 32'h40, 1, 1);
    repeat (6) @(negedge clk);
    chk("err_sticky", 32'(err_timeout), 1);
    chk("wait_pulse", 32'(n_pulse), 32'(p0 + 1));
    #2 reset = 1'b0;
    #1;
    chk("arst_desc_ready", 32'(bus.desc_ready), 0);
    chk("arst_wr_ctrl", 32'(bus.wr_ctrl), 0);
    chk("arst_pkt_begin", bus.pkt_begin, 0);
    chk("arst_pkt_end", bus.pkt_end, 0);
    chk("arst_write_address", bus.write_address, 0);
    chk("arst_control", bus.control, 0);
    chk("arst_wr_off", wr_off, 0);
    chk("arst_pkt_count", pkt_count, 0);
    chk("arst_drop_count", 32'(drop_count), 0);
    chk("arst_err", 32'(err_timeout), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
